bus_arbiter_mux: RTL and testbench



---
 rtl/bus_arbiter_mux_if.sv | 26 ++
 rtl/bus_arbiter_mux.sv | 62 ++++++
 tb/tb_bus_arbiter_mux.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_mux_if.sv
// bus_arbiter_mux_if: source/control inputs and registered bus outputs of the bus arbiter
interface bus_arbiter_mux_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 26,
    parameter int CNT_W   = 8
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_out;
    logic                     hold;
    logic                     conflict_clr;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [IDX_W-1:0]         bus_sel;
    logic                     conflict;
    logic                     conflict_sticky;
    logic [CNT_W-1:0]         conflict_cnt;
    modport master (
        output src_data, src_out, hold, conflict_clr,
        input  bus_out, bus_valid, bus_sel, conflict, conflict_sticky, conflict_cnt
    );
    modport slave (
        input  src_data, src_out, hold, conflict_clr,
        output bus_out, bus_valid, bus_sel, conflict, conflict_sticky, conflict_cnt
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered fixed-priority/round-robin bus mux with out-enable conflict tracking
module bus_arbiter_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 26,
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 8
) (
    input logic             clk,
    input logic             clr,
    bus_arbiter_mux_if.slave bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] hi_idx;
    logic             hi_ok;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ptr_nx;
    logic             gnt;
    logic             multi;
    logic [CNT_W-1:0] cnt_nx;
    // grant selection: lowest set bit overall, and lowest set bit at or above the RR pointer
    always_comb begin
        fix_idx = '0;
        hi_idx  = '0;
        hi_ok   = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.src_out[i]) fix_idx = IDX_W'(i);
            if (bus.src_out[i] && i >= int'(rr_ptr)) begin
                hi_idx = IDX_W'(i);
                hi_ok  = 1'b1;
            end
        end
        idx    = (RR_MODE != 0 && hi_ok) ? hi_idx : fix_idx;
        gnt    = |bus.src_out;
        ptr_nx = (idx == IDX_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
        multi  = |(bus.src_out & (bus.src_out - NUM_SRC'(1)));
        cnt_nx = bus.conflict_clr ? CNT_W'(multi) : (multi && !(&bus.conflict_cnt)) ? bus.conflict_cnt + 1'b1 : bus.conflict_cnt;
    end
    // bus/index/pointer registers honour hold; conflict tracking runs every cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus.bus_out         <= '0;
            bus.bus_valid       <= 1'b0;
            bus.bus_sel         <= '0;
            bus.conflict        <= 1'b0;
            bus.conflict_sticky <= 1'b0;
            bus.conflict_cnt    <= '0;
            rr_ptr              <= '0;
        end else begin
            if (!bus.hold) begin
                bus.bus_out   <= gnt ? bus.src_data[idx*WIDTH +: WIDTH] : '0;
                bus.bus_valid <= gnt;
                bus.bus_sel   <= gnt ? idx : '0;
                if (gnt) rr_ptr <= ptr_nx;
            end
            bus.conflict        <= multi;
            bus.conflict_sticky <= multi | (bus.conflict_sticky & ~bus.conflict_clr);
            bus.conflict_cnt    <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: table-driven vectors through an expected-value queue for a fixed-priority and a round-robin instance
module tb_bus_arbiter_mux;
    typedef struct {
        logic [25:0] so;
        logic        h;
        logic        cc;
        logic [31:0] bus;
        logic [4:0]  sel;
        logic        v;
        logic        c;
        logic        sk;
        logic [1:0]  cnt;
    } va_t;
    typedef struct {
        logic [3:0] so;
        logic       h;
        logic [1:0] sel;
        logic       v;
        logic       c;
        logic [7:0] cnt;
    } vb_t;
    typedef struct {
        bit          isb;
        int          id;
        logic [31:0] bus;
        logic [31:0] sel;
        logic [31:0] v;
        logic [31:0] c;
        logic [31:0] sk;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic clr;
    int n_vec = 0;
    int n_bad = 0;
    exp_t sb[$];
    exp_t e;
    logic [31:0] da_a [26];
    va_t va [17];
    vb_t vb [15];

    bus_arbiter_mux_if #(.WIDTH(32), .NUM_SRC(26), .CNT_W(2)) ia ();
    bus_arbiter_mux_if #(.WIDTH(32), .NUM_SRC(4), .CNT_W(8)) ib ();

    bus_arbiter_mux #(.WIDTH(32), .NUM_SRC(26), .RR_MODE(0), .CNT_W(2)) ua (.clk(clk), .clr(clr), .bus(ia));
    bus_arbiter_mux #(.WIDTH(32), .NUM_SRC(4), .RR_MODE(1), .CNT_W(8)) ub (.clk(clk), .clr(clr), .bus(ib));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        n_vec++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, x);
        end
    endtask

    task automatic pack_a();
        for (int i = 0; i < 26; i++) ia.src_data[i*32 +: 32] = da_a[i];
    endtask

    task automatic rst_chk(input string t);
        chk({t, ".a_bus"}, ia.bus_out, 32'h0);
        chk({t, ".a_sel"}, 32'(ia.bus_sel), 32'h0);
        chk({t, ".a_valid"}, 32'(ia.bus_valid), 32'h0);
        chk({t, ".a_conf"}, 32'(ia.conflict), 32'h0);
        chk({t, ".a_sticky"}, 32'(ia.conflict_sticky), 32'h0);
        chk({t, ".a_cnt"}, 32'(ia.conflict_cnt), 32'h0);
        chk({t, ".b_bus"}, ib.bus_out, 32'h0);
        chk({t, ".b_sel"}, 32'(ib.bus_sel), 32'h0);
        chk({t, ".b_valid"}, 32'(ib.bus_valid), 32'h0);
        chk({t, ".b_conf"}, 32'(ib.conflict), 32'h0);
        chk({t, ".b_sticky"}, 32'(ib.conflict_sticky), 32'h0);
        chk({t, ".b_cnt"}, 32'(ib.conflict_cnt), 32'h0);
    endtask

    task automatic push_b(input int id, input vb_t r);
        exp_t x;
        x.isb = 1'b1;
        x.id  = id;
        x.bus = r.v ? (32'hB0B00000 | 32'(r.sel)) : 32'h0;
        x.sel = 32'(r.sel);
        x.v   = 32'(r.v);
        x.c   = 32'(r.c);
        x.sk  = 32'(r.cnt != 8'd0);
        x.cnt = 32'(r.cnt);
        sb.push_back(x);
    endtask

    task automatic push_a(input int id, input va_t r);
        exp_t x;
        x.isb = 1'b0;
        x.id  = id;
        x.bus = r.bus;
        x.sel = 32'(r.sel);
        x.v   = 32'(r.v);
        x.c   = 32'(r.c);
        x.sk  = 32'(r.sk);
        x.cnt = 32'(r.cnt);
        sb.push_back(x);
    endtask

    // compare every queued expectation one step after the edge that produced it
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.isb) begin
                chk($sformatf("B%0d.bus", e.id), ib.bus_out, e.bus);
                chk($sformatf("B%0d.sel", e.id), 32'(ib.bus_sel), e.sel);
                chk($sformatf("B%0d.valid", e.id), 32'(ib.bus_valid), e.v);
                chk($sformatf("B%0d.conf", e.id), 32'(ib.conflict), e.c);
                chk($sformatf("B%0d.sticky", e.id), 32'(ib.conflict_sticky), e.sk);
                chk($sformatf("B%0d.cnt", e.id), 32'(ib.conflict_cnt), e.cnt);
            end else begin
                chk($sformatf("A%0d.bus", e.id), ia.bus_out, e.bus);
                chk($sformatf("A%0d.sel", e.id), 32'(ia.bus_sel), e.sel);
                chk($sformatf("A%0d.valid", e.id), 32'(ia.bus_valid), e.v);
                chk($sformatf("A%0d.conf", e.id), 32'(ia.conflict), e.c);
                chk($sformatf("A%0d.sticky", e.id), 32'(ia.conflict_sticky), e.sk);
                chk($sformatf("A%0d.cnt", e.id), 32'(ia.conflict_cnt), e.cnt);
            end
        end
    end

    initial begin
        va[0]  = '{26'h0100008, 1'b0, 1'b0, 32'hAAAA0003, 5'd3,  1'b1, 1'b1, 1'b1, 2'd1};
        va[1]  = '{26'h0000020, 1'b0, 1'b1, 32'h12345678, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0};
        va[2]  = '{26'h0000080, 1'b1, 1'b0, 32'h12345678, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0};
        va[3]  = '{26'h0000080, 1'b1, 1'b0, 32'h12345678, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0};
        va[4]  = '{26'h0000080, 1'b1, 1'b0, 32'h12345678, 5'd5,  1'b1, 1'b0, 1'b0, 2'd0};
        va[5]  = '{26'h0000080, 1'b0, 1'b0, 32'h77777777, 5'd7,  1'b1, 1'b0, 1'b0, 2'd0};
        va[6]  = '{26'h0000000, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0};
        va[7]  = '{26'h0000000, 1'b1, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0};
        va[8]  = '{26'h0000006, 1'b0, 1'b0, 32'hA5000001, 5'd1,  1'b1, 1'b1, 1'b1, 2'd1};
        va[9]  = '{26'h0000006, 1'b0, 1'b0, 32'hA5000001, 5'd1,  1'b1, 1'b1, 1'b1, 2'd2};
        va[10] = '{26'h0000C00, 1'b1, 1'b0, 32'hA5000001, 5'd1,  1'b1, 1'b1, 1'b1, 2'd3};
        va[11] = '{26'h0000006, 1'b0, 1'b0, 32'hA5000001, 5'd1,  1'b1, 1'b1, 1'b1, 2'd3};
        va[12] = '{26'h0000006, 1'b0, 1'b0, 32'hA5000001, 5'd1,  1'b1, 1'b1, 1'b1, 2'd3};
        va[13] = '{26'h2000001, 1'b0, 1'b1, 32'hA5000000, 5'd0,  1'b1, 1'b1, 1'b1, 2'd1};
        va[14] = '{26'h2000000, 1'b0, 1'b1, 32'hA5000019, 5'd25, 1'b1, 1'b0, 1'b0, 2'd0};
        va[15] = '{26'h0000050, 1'b0, 1'b0, 32'hA5000004, 5'd4,  1'b1, 1'b1, 1'b1, 2'd1};
        va[16] = '{26'h0000000, 1'b0, 1'b0, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1, 2'd1};
        vb[0]  = '{4'b1011, 1'b0, 2'd0, 1'b1, 1'b1, 8'd1};
        vb[1]  = '{4'b1011, 1'b0, 2'd1, 1'b1, 1'b1, 8'd2};
        vb[2]  = '{4'b1011, 1'b0, 2'd3, 1'b1, 1'b1, 8'd3};
        vb[3]  = '{4'b1011, 1'b0, 2'd0, 1'b1, 1'b1, 8'd4};
        vb[4]  = '{4'b1111, 1'b0, 2'd1, 1'b1, 1'b1, 8'd5};
        vb[5]  = '{4'b1111, 1'b0, 2'd2, 1'b1, 1'b1, 8'd6};
        vb[6]  = '{4'b1111, 1'b0, 2'd3, 1'b1, 1'b1, 8'd7};
        vb[7]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 1'b1, 8'd8};
        vb[8]  = '{4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 8'd9};
        vb[9]  = '{4'b1111, 1'b0, 2'd1, 1'b1, 1'b1, 8'd10};
        vb[10] = '{4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd10};
        vb[11] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 8'd10};
        vb[12] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd10};
        vb[13] = '{4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 8'd10};
        vb[14] = '{4'b0110, 1'b0, 2'd1, 1'b1, 1'b1, 8'd11};
        for (int i = 0; i < 26; i++) da_a[i] = 32'hA5000000 | 32'(i);
        da_a[3]  = 32'hAAAA0003;
        da_a[20] = 32'h0000BEEF;
        da_a[5]  = 32'h12345678;
        da_a[7]  = 32'h77777777;
        pack_a();
        for (int i = 0; i < 4; i++) ib.src_data[i*32 +: 32] = 32'hB0B00000 | 32'(i);
        clr = 1'b1;
        ia.src_out = '1;
        ib.src_out = '1;
        ia.hold = 1'b0;
        ib.hold = 1'b0;
        ia.conflict_clr = 1'b0;
        ib.conflict_clr = 1'b0;
        @(negedge clk);
        rst_chk("init");
        clr = 1'b0;
        ia.src_out = '0;
        ib.src_out = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            ib.src_out = vb[k].so;
            ib.hold = vb[k].h;
            push_b(k, vb[k]);
        end
        @(negedge clk);
        ib.src_out = '0;
        ib.hold = 1'b0;
        for (int k = 0; k < 17; k++) begin
            if (k != 0) @(negedge clk);
            da_a[5] = va[k].h ? 32'hDEAD0005 : 32'h12345678;
            pack_a();
            ia.src_out = va[k].so;
            ia.hold = va[k].h;
            ia.conflict_clr = va[k].cc;
            push_a(k, va[k]);
        end
        @(negedge clk);
        ia.hold = 1'b0;
        ia.conflict_clr = 1'b0;
        ib.src_out = 4'b0110;
        @(negedge clk);
        clr = 1'b1;
        ia.src_out = '1;
        ib.src_out = '1;
        #1;
        rst_chk("async");
        @(posedge clk);
        #1;
        rst_chk("held");
        @(negedge clk);
        clr = 1'b0;
        ia.src_out = '0;
        ib.src_out = '0;
        @(negedge clk);
        ib.src_out = 4'b1111;
        push_b(100, '{4'b1111, 1'b0, 2'd0, 1'b1, 1'b1, 8'd1});
        push_a(100, '{26'h0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0});
        @(negedge clk);
        ib.src_out = '0;
        @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
